// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: hands out rename tags, reclaims them at retire, restores head on revert.
// Optional feature macro FREE_LIST_ENQ_BYPASS_EN: a legal enqueue into an empty list is visible to dequeue in the same cycle.
module phys_reg_free_list #(
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
    input  logic                             CLK,
    input  logic                             nRST,
    output logic                             DUT_error,
    output logic                             dequeue_valid,
    output logic [$clog2(NUM_PHYS_REGS)-1:0] dequeue_phys_reg_tag,
    input  logic                             dequeue_ready,
    input  logic                             enqueue_valid,
    input  logic [$clog2(NUM_PHYS_REGS)-1:0] enqueue_phys_reg_tag,
    output logic [$clog2(DEPTH):0]           head_ptr,
    input  logic                             revert_valid,
    input  logic [$clog2(DEPTH):0]           revert_head_ptr
);
    localparam int unsigned TAG_W = $clog2(NUM_PHYS_REGS);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [TAG_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W-1:0] tail_nxt;
    logic             error_nxt;
    logic             empty;
    logic             full;
    logic             tag_legal;
    logic             bypass;
    logic             deq_fire;
    logic             enq_fire;

    // Occupancy, handshake and next-state decode; fullness always judged on current state.
    always_comb begin
        empty                = 1'b0;
        full                 = 1'b0;
        tag_legal            = 1'b0;
        bypass               = 1'b0;
        dequeue_valid        = 1'b0;
        dequeue_phys_reg_tag = '0;
        head_ptr             = head;
        deq_fire             = 1'b0;
        enq_fire             = 1'b0;
        head_nxt             = head;
        tail_nxt             = tail;
        error_nxt            = 1'b0;

        empty     = (head == tail);
        full      = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
        tag_legal = enqueue_valid && (enqueue_phys_reg_tag != '0);
`ifdef FREE_LIST_ENQ_BYPASS_EN
        bypass    = empty && tag_legal && !revert_valid;
`else
        bypass    = 1'b0;
`endif
        dequeue_valid        = !empty || bypass;
        dequeue_phys_reg_tag = bypass ? enqueue_phys_reg_tag : entries[head[IDX_W-1:0]];

        // A revert discards any same-cycle dequeue without flagging it.
        deq_fire = dequeue_valid && dequeue_ready && !revert_valid;
        enq_fire = tag_legal && !full;

        if (revert_valid) begin
            head_nxt = revert_head_ptr;
        end else if (deq_fire) begin
            head_nxt = head + PTR_W'(1);
        end
        if (enq_fire) begin
            tail_nxt = tail + PTR_W'(1);
        end

        error_nxt = (dequeue_ready && !dequeue_valid && !revert_valid)
                  || (enqueue_valid && (full || (enqueue_phys_reg_tag == '0)));
    end

    // State registers; reset loads the unmapped tags NUM_ARCH_REGS.. so the list starts full.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head      <= '0;
            tail      <= PTR_W'(DEPTH);
            DUT_error <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= TAG_W'(NUM_ARCH_REGS + i);
            end
        end else begin
            head      <= head_nxt;
            tail      <= tail_nxt;
            DUT_error <= error_nxt;
            if (enq_fire) begin
                entries[tail[IDX_W-1:0]] <= enqueue_phys_reg_tag;
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed corner cases plus randomized traffic against a tag-queue model.
// Honours FREE_LIST_ENQ_BYPASS_EN to expect same-cycle visibility of enqueues into an empty list.
module tb_phys_reg_free_list;
    localparam int unsigned TAG_W = 6;
    localparam int unsigned PTR_W = 6;
`ifdef FREE_LIST_ENQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             nRST;
    logic             DUT_error;
    logic             dequeue_valid;
    logic [TAG_W-1:0] dequeue_phys_reg_tag;
    logic             dequeue_ready;
    logic             enqueue_valid;
    logic [TAG_W-1:0] enqueue_phys_reg_tag;
    logic [PTR_W-1:0] head_ptr;
    logic             revert_valid;
    logic [PTR_W-1:0] revert_head_ptr;

    int n_checks = 0;
    int n_errors = 0;

    phys_reg_free_list dut (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .DUT_error            (DUT_error),
        .dequeue_valid        (dequeue_valid),
        .dequeue_phys_reg_tag (dequeue_phys_reg_tag),
        .dequeue_ready        (dequeue_ready),
        .enqueue_valid        (enqueue_valid),
        .enqueue_phys_reg_tag (enqueue_phys_reg_tag),
        .head_ptr             (head_ptr),
        .revert_valid         (revert_valid),
        .revert_head_ptr      (revert_head_ptr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        dequeue_ready        = 1'b0;
        enqueue_valid        = 1'b0;
        enqueue_phys_reg_tag = '0;
        revert_valid         = 1'b0;
        revert_head_ptr      = '0;
        nRST                 = 1'b0;
        #1;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    // Reference model: ordered queue of available tags, tags held by dispatch, head as a free-running count.
    logic [TAG_W-1:0] q[$];
    logic [TAG_W-1:0] held[$];
    int               mhead;
    logic             do_enq;
    logic [TAG_W-1:0] etag;
    logic             exp_valid;
    logic [TAG_W-1:0] exp_tag;
    int               pick;

    initial begin
        apply_reset();

        // Reset contents and full drain.
        check("reset_err", 32'(DUT_error), 32'd0);
        for (int i = 0; i < 32; i++) begin
            check("drain_valid", 32'(dequeue_valid), 32'd1);
            check("drain_tag", 32'(dequeue_phys_reg_tag), 32'(32 + i));
            check("drain_head", 32'(head_ptr), 32'(i));
            dequeue_ready = 1'b1;
            tick();
        end
        dequeue_ready = 1'b0;
        check("empty_valid", 32'(dequeue_valid), 32'd0);
        check("empty_head", 32'(head_ptr), 32'd32);
        check("empty_err", 32'(DUT_error), 32'd0);

        // Dequeue while empty.
        dequeue_ready = 1'b1;
        tick();
        dequeue_ready = 1'b0;
        check("underflow_err", 32'(DUT_error), 32'd1);
        check("underflow_head", 32'(head_ptr), 32'd32);
        tick();
        check("underflow_err_clr", 32'(DUT_error), 32'd0);

        // Enqueue into empty list, with or without bypass.
        enqueue_valid        = 1'b1;
        enqueue_phys_reg_tag = 6'd40;
        #1;
        check("enq_same_valid", 32'(dequeue_valid), 32'(BYP));
        if (BYP) check("enq_same_tag", 32'(dequeue_phys_reg_tag), 32'd40);
        tick();
        enqueue_valid = 1'b0;
        check("enq_next_valid", 32'(dequeue_valid), 32'd1);
        check("enq_next_tag", 32'(dequeue_phys_reg_tag), 32'd40);
        check("enq_next_err", 32'(DUT_error), 32'd0);

        // Tag 0 is rejected and not stored.
        enqueue_valid        = 1'b1;
        enqueue_phys_reg_tag = 6'd0;
        tick();
        enqueue_valid = 1'b0;
        check("tag0_err", 32'(DUT_error), 32'd1);
        check("tag0_tag", 32'(dequeue_phys_reg_tag), 32'd40);
        dequeue_ready = 1'b1;
        tick();
        dequeue_ready = 1'b0;
        check("tag0_dropped_valid", 32'(dequeue_valid), 32'd0);
        check("tag0_dropped_head", 32'(head_ptr), 32'd33);

        // Asynchronous reset mid-operation.
        nRST = 1'b0;
        #1;
        check("async_rst_valid", 32'(dequeue_valid), 32'd1);
        check("async_rst_tag", 32'(dequeue_phys_reg_tag), 32'd32);
        check("async_rst_head", 32'(head_ptr), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;

        // Checkpoint at 2, advance 3, revert with a competing dequeue.
        dequeue_ready = 1'b1;
        tick();
        tick();
        check("ckpt_head", 32'(head_ptr), 32'd2);
        tick();
        tick();
        tick();
        check("pre_revert_head", 32'(head_ptr), 32'd5);
        check("pre_revert_tag", 32'(dequeue_phys_reg_tag), 32'd37);
        revert_valid    = 1'b1;
        revert_head_ptr = 6'd2;
        tick();
        revert_valid  = 1'b0;
        dequeue_ready = 1'b0;
        check("revert_tag", 32'(dequeue_phys_reg_tag), 32'd34);
        check("revert_head", 32'(head_ptr), 32'd2);
        check("revert_err", 32'(DUT_error), 32'd0);

        // Enqueue into a full list while a dequeue fires in the same cycle.
        apply_reset();
        dequeue_ready        = 1'b1;
        enqueue_valid        = 1'b1;
        enqueue_phys_reg_tag = 6'd45;
        tick();
        dequeue_ready = 1'b0;
        enqueue_valid = 1'b0;
        check("overflow_err", 32'(DUT_error), 32'd1);
        check("overflow_head", 32'(head_ptr), 32'd1);
        check("overflow_tag", 32'(dequeue_phys_reg_tag), 32'd33);
        tick();
        check("overflow_err_clr", 32'(DUT_error), 32'd0);

        // Randomized dequeue/enqueue traffic; freed tags are ones previously handed out.
        apply_reset();
        q.delete();
        held.delete();
        for (int i = 0; i < 32; i++) q.push_back(TAG_W'(32 + i));
        mhead = 0;
        for (int c = 0; c < 300; c++) begin
            do_enq = (held.size() > 0) && ($urandom_range(1, 0) == 1);
            etag   = '0;
            if (do_enq) begin
                pick = int'($urandom_range(held.size() - 1, 0));
                etag = held[pick];
                held.delete(pick);
            end
            exp_valid = (q.size() > 0) || (BYP && do_enq);
            exp_tag   = (q.size() > 0) ? q[0] : etag;
            enqueue_valid        = do_enq;
            enqueue_phys_reg_tag = etag;
            dequeue_ready        = exp_valid && ($urandom_range(1, 0) == 1);
            #1;
            check("rnd_valid", 32'(dequeue_valid), 32'(exp_valid));
            if (exp_valid) check("rnd_tag", 32'(dequeue_phys_reg_tag), 32'(exp_tag));
            check("rnd_head", 32'(head_ptr), 32'(mhead));
            check("rnd_err", 32'(DUT_error), 32'd0);
            if (do_enq) q.push_back(etag);
            if (dequeue_ready && exp_valid) begin
                held.push_back(q.pop_front());
                mhead = (mhead + 1) % 64;
            end
            tick();
        end
        dequeue_ready = 1'b0;
        enqueue_valid = 1'b0;
        #1;
        check("rnd_final_err", 32'(DUT_error), 32'd0);
        check("rnd_final_head", 32'(head_ptr), 32'(mhead));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
